pipeline_sink: RTL and testbench
================================

# pipeline_sink

Output buffer placed directly downstream of the valid-qualified, enable-stalled data pipeline. Captures `valid`/`data` words leaving the last pipeline stage into a small first-word-fall-through FIFO and presents them on a ready/valid interface. Drives the pipeline's enable so the pipeline freezes exactly when the FIFO cannot accept a word. Guarantees no word is ever dropped or duplicated.

## Interface
- `DW`, 64, data width in bits
- `DEPTH`, 4, FIFO entries; power of two, ≥ 2
- `CW`, `$clog2(DEPTH+1)`, width of the `count` output (derived, not overridden)

Ports:
- `clk`  in  1  single clock, rising edge
- `nreset`  in  1  reset; asynchronous and active-low
- `in_valid`  in  1  valid from last pipeline stage
- `in_data`  in  DW  data from last pipeline stage
- `en_out`  out  1  pipeline enable; connect to the pipeline's `en`
- `out_valid`  out  1  head entry present
- `out_ready`  in  1  downstream accepts head entry
- `out_data`  out  DW  head entry data
- `count`  out  CW  current occupancy, 0..DEPTH
- `full`  out  1  `count == DEPTH`
- `empty`  out  1  `count == 0`

## Operation
- pop = `out_valid & out_ready`.
- `en_out = ~full | pop` (combinational). The pipeline advances only when a slot is free now or is freed this cycle.
- push = `in_valid & en_out`. When `en_out` is low, the pipeline holds its output, so the same word is re-presented later. It is never captured twice.
- Storage: DEPTH×DW register array with write pointer, read pointer (log2 DEPTH bits, natural wrap) and occupancy counter.
- Push writes `in_data` at `wr_ptr` and increments `wr_ptr`. Pop increments `rd_ptr`.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- `out_data = mem[rd_ptr]` (FWFT). `out_data` is don't-care while `out_valid` is low.
- `out_valid = ~empty`. It is independent of `out_ready`, and once high it holds until popped.
- Overflow is impossible by construction. The bench asserts `~(push & full & ~pop)`.
- Underflow is impossible: pop requires `out_valid`.

## Timing
- Reset values:
  - `count` 0, pointers 0, `empty` 1, `full` 0, `out_valid` 0
  - `en_out` 1, since it follows `~full`
  - array contents are not reset
- Latency: a word pushed at edge k is visible on `out_valid`/`out_data` after edge k.
- Throughput: one word per cycle sustained when `out_ready` is held high.
- Full with push and pop in the same cycle: both occur, `count` stays at DEPTH, `en_out` stays high.
- Full with no pop: `en_out` goes low in the same cycle, the pipeline freezes, and `count` holds.
- Empty with push: `out_valid` rises the next cycle. There is no same-cycle bypass.
- Pointer wrap from DEPTH−1 to 0 is silent.
- Reset asserted mid-operation: all state clears immediately and asynchronously, and buffered words are discarded. The pipeline's own async reset clears in-flight words concurrently.
- `out_ready` may toggle freely. `out_data` changes only on pop or when the FIFO goes from empty to non-empty.

## Configuration
- `PIPELINE_SINK_STALLCNT_EN`: when defined, adds output `stall_count` (32 bits, reset 0).
  - Increments every cycle in which `in_valid & ~en_out` (a backpressure stall).
  - Saturates at 2^32−1.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package `pipeline_pkg`:
  - default `DW`
  - `DEPTH` legality check constant
  - stall counter width constant (32)
- One natural sub-module, `pipeline_sink_ram`: DEPTH×DW register array with single write port and combinational read port. Pointer, count and enable logic stay in the top module.

## Test plan
- **Reset/idle:** hold `nreset`=0 then release → `empty`=1, `count`=0, `out_valid`=0, `en_out`=1.
- **Streaming:** DEPTH=4, push 0x1..0x10 on consecutive cycles with `out_ready`=1 → output 0x1..0x10 in order, one per cycle, 1-cycle latency, `count` ≤ 1.
- **Fill and stall:** `out_ready`=0, push 0xA,0xB,0xC,0xD,0xE → `full`=1 after 4th push, `en_out`=0 while 0xE held, `count`=4. Then `out_ready`=1 → outputs 0xA..0xE, no duplicate 0xE.
- **Full with simultaneous push/pop:** FIFO full, `in_valid`=1, `out_ready`=1 for 8 cycles → `count` stays 4, `en_out`=1, order preserved across pointer wrap.
- **Reset mid-operation:** 3 entries buffered, pulse `nreset` low for 1 ns → `count`=0, `out_valid`=0 asynchronously. Next push 0x55 appears alone.
- **`PIPELINE_SINK_STALLCNT_EN` defined:** full FIFO, `in_valid`=1, `out_ready`=0 for 10 cycles → `stall_count`=10.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants and helpers for the pipeline output-buffer slice.
package pipeline_pkg;

    localparam int DW_DEFAULT    = 64;
    localparam int DEPTH_DEFAULT = 4;
    localparam int DEPTH_MIN     = 2;
    localparam int STALL_CW      = 32;

    function automatic bit depth_is_legal(input int depth);
        return (depth >= DEPTH_MIN) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/pipeline_sink_ram.sv
// DEPTH x DW register array: one synchronous write port, one combinational read port.
module pipeline_sink_ram #(
    parameter int DW    = 64,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem_r [DEPTH];

    // Storage is deliberately not reset; occupancy tracking makes stale contents invisible.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/pipeline_sink.sv
// FWFT output buffer that back-pressures an enable-stalled pipeline without drop or duplication.
// Optional stall counter output enabled by defining PIPELINE_SINK_STALLCNT_EN.
module pipeline_sink
    import pipeline_pkg::*;
#(
    parameter  int DW    = DW_DEFAULT,
    parameter  int DEPTH = DEPTH_DEFAULT,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                clk,
    input  logic                nreset,
    input  logic                in_valid,
    input  logic [DW-1:0]       in_data,
    output logic                en_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic [CW-1:0]       count,
    output logic                full,
    output logic                empty
`ifdef PIPELINE_SINK_STALLCNT_EN
    ,
    output logic [STALL_CW-1:0] stall_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    if (!depth_is_legal(DEPTH)) begin : g_depth_check
        $error("pipeline_sink: DEPTH must be a power of two and at least 2");
    end

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          full_s;
    logic          empty_s;
    logic          en_s;
    logic          push_s;
    logic          pop_s;

    assign full_s  = (count_r == CW'(DEPTH));
    assign empty_s = (count_r == {CW{1'b0}});
    assign pop_s   = ~empty_s & out_ready;
    // A slot freed by this cycle's pop may be refilled in the same cycle.
    assign en_s    = ~full_s | pop_s;
    assign push_s  = in_valid & en_s;

    assign en_out    = en_s;
    assign out_valid = ~empty_s;
    assign count     = count_r;
    assign full      = full_s;
    assign empty     = empty_s;

    pipeline_sink_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (push_s),
        .waddr (wr_ptr_r),
        .wdata (in_data),
        .raddr (rd_ptr_r),
        .rdata (out_data)
    );

    // Write pointer advances on every accepted word, wrapping naturally.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_r <= {AW{1'b0}};
        end else if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
        end else begin
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Read pointer advances on every pop, wrapping naturally.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rd_ptr_r <= {AW{1'b0}};
        end else if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
        end else begin
            rd_ptr_r <= rd_ptr_r;
        end
    end

    // Occupancy: simultaneous push and pop cancel out.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            count_r <= {CW{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef PIPELINE_SINK_STALLCNT_EN
    logic [STALL_CW-1:0] stall_count_r;

    // Counts cycles where the pipeline holds a valid word because the buffer is full; saturating.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stall_count_r <= {STALL_CW{1'b0}};
        end else if (in_valid && !en_s && (stall_count_r != {STALL_CW{1'b1}})) begin
            stall_count_r <= stall_count_r + STALL_CW'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;
`endif

endmodule

// File: tb/tb_pipeline_sink.sv
// Directed self-checking bench for pipeline_sink (DW=64, DEPTH=4).
module tb_pipeline_sink;

    logic        clk;
    logic        nreset;
    logic        in_valid;
    logic [63:0] in_data;
    logic        en_out;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [2:0]  count;
    logic        full;
    logic        empty;
`ifdef PIPELINE_SINK_STALLCNT_EN
    logic [31:0] stall_count;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    pipeline_sink #(.DW(64), .DEPTH(4)) dut (
        .clk       (clk),
        .nreset    (nreset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .en_out    (en_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
`ifdef PIPELINE_SINK_STALLCNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Overflow must never happen: no push into a full buffer without a pop.
    always @(negedge clk) begin
        if (nreset === 1'b1) begin
            n_assert++;
            assert (!((in_valid & en_out) & full & ~(out_valid & out_ready))) else begin
                n_fail++;
                $error("FAIL overflow: observed push into full buffer expected none");
            end
        end
    end

    initial begin
        nreset    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 64'h0;
        out_ready = 1'b0;

        // Reset / idle
        #12;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_en_out", 64'(en_out), 64'd1);
`ifdef PIPELINE_SINK_STALLCNT_EN
        chk("rst_stall_count", 64'(stall_count), 64'd0);
`endif
        nreset = 1'b1;
        cyc();
        chk("idle_empty", 64'(empty), 64'd1);
        chk("idle_en_out", 64'(en_out), 64'd1);

        // Streaming with out_ready held high: 1-cycle latency, count stays at most 1
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            #2;
            chk("stream_en_out", 64'(en_out), 64'd1);
            if (i == 1) begin
                chk("stream_first_empty", 64'(out_valid), 64'd0);
            end else begin
                chk("stream_out_valid", 64'(out_valid), 64'd1);
                chk("stream_out_data", out_data, 64'(i - 1));
                chk("stream_count", 64'(count), 64'd1);
            end
            cyc();
        end
        in_valid = 1'b0;
        #2;
        chk("stream_last_data", out_data, 64'h10);
        chk("stream_last_count", 64'(count), 64'd1);
        cyc();
        chk("stream_drained", 64'(empty), 64'd1);

        // Fill and stall
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 64'hA + 64'(i);
            #2;
            chk("fill_en_out", 64'(en_out), 64'd1);
            cyc();
        end
        in_data = 64'hE;
        #2;
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd4);
        chk("fill_en_low", 64'(en_out), 64'd0);
        chk("fill_head", out_data, 64'hA);
        cyc();
        #2;
        chk("hold_count", 64'(count), 64'd4);
        chk("hold_en_low", 64'(en_out), 64'd0);
        out_ready = 1'b1;
        #1;
        chk("release_en_out", 64'(en_out), 64'd1);
        chk("release_head", out_data, 64'hA);
        cyc();
        in_valid = 1'b0;
        for (int i = 1; i < 5; i++) begin
            #2;
            chk("drain_out_valid", 64'(out_valid), 64'd1);
            chk("drain_data", out_data, 64'hA + 64'(i));
            cyc();
        end
        #2;
        chk("no_dup_E", 64'(out_valid), 64'd0);
        cyc();

        // Full with simultaneous push and pop across pointer wrap
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h100 + 64'(i);
            cyc();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            in_data = 64'h104 + 64'(j);
            #2;
            chk("pp_count", 64'(count), 64'd4);
            chk("pp_en_out", 64'(en_out), 64'd1);
            chk("pp_data", out_data, 64'h100 + 64'(j));
            cyc();
        end
        in_valid = 1'b0;
        for (int j = 8; j < 12; j++) begin
            #2;
            chk("pp_drain_data", out_data, 64'h100 + 64'(j));
            cyc();
        end
        #2;
        chk("pp_empty", 64'(empty), 64'd1);
        cyc();

        // Reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h21 + 64'(i);
            cyc();
        end
        in_valid = 1'b0;
        #2;
        chk("mid_count_before", 64'(count), 64'd3);
        nreset = 1'b0;
        #1;
        chk("mid_async_count", 64'(count), 64'd0);
        chk("mid_async_out_valid", 64'(out_valid), 64'd0);
        nreset = 1'b1;
        cyc();
        in_valid = 1'b1;
        in_data  = 64'h55;
        cyc();
        in_valid = 1'b0;
        #2;
        chk("post_rst_data", out_data, 64'h55);
        chk("post_rst_count", 64'(count), 64'd1);
        out_ready = 1'b1;
        cyc();
        #2;
        chk("post_rst_alone", 64'(empty), 64'd1);

`ifdef PIPELINE_SINK_STALLCNT_EN
        // Stall counter: 10 backpressure cycles on a full buffer
        nreset = 1'b0;
        #1;
        nreset = 1'b1;
        cyc();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 64'h77;
        for (int i = 0; i < 4; i++) cyc();
        for (int i = 0; i < 10; i++) cyc();
        in_valid = 1'b0;
        #2;
        chk("stall_count", 64'(stall_count), 64'd10);
        chk("stall_full_count", 64'(count), 64'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
